// File: rtl/fifo_pkg.sv
// Shared constants, operation encoding and depth helper for the synchronous FIFO.
// Imported by fifo_ptr_ctrl and fifo_buffer.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32'sd8;
  localparam int DEFAULT_ADDR_WIDTH = 32'sd4;
  localparam int DEFAULT_AE_THRESH  = 32'sd2;
  localparam int AF_MARGIN          = 32'sd2;

  // Encoding of {write accepted, read accepted} for the occupancy update.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int depth_of(input int addr_width);
    return int'(32'd1 << addr_width);
  endfunction

  function automatic int default_af_thresh(input int addr_width);
    return depth_of(addr_width) - AF_MARGIN;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, flag and error control for fifo_buffer.
// Wrap-bit pointers make all 2**ADDR_WIDTH entries usable.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = default_af_thresh(ADDR_WIDTH),
  parameter int AE_THRESH  = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clear_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = AE_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr_r;
  logic [ADDR_WIDTH:0] rd_ptr_r;
  logic [ADDR_WIDTH:0] count_r;
  logic                overflow_r;
  logic                underflow_r;

  logic                empty_s;
  logic                full_s;
  logic                wr_acc_s;
  logic                rd_acc_s;
  fifo_op_e            op_s;
  logic [ADDR_WIDTH:0] count_nxt_s;
  logic                overflow_nxt_s;
  logic                underflow_nxt_s;

  // Status decode and request acceptance from start-of-cycle state only.
  always_comb begin
    empty_s  = (wr_ptr_r == rd_ptr_r);
    full_s   = (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
               (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]);
    // A write into a full FIFO is fine when the same-cycle read frees the slot.
    wr_acc_s = write & (~full_s | read);
    rd_acc_s = read & ~empty_s;
    op_s     = fifo_op_e'({wr_acc_s, rd_acc_s});
  end

  // Next occupancy and sticky error flags; a new error beats clear_err.
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      OP_WRITE: count_nxt_s = count_r + PTR_ONE;
      OP_READ:  count_nxt_s = count_r - PTR_ONE;
      OP_BOTH:  count_nxt_s = count_r;
      OP_IDLE:  count_nxt_s = count_r;
      default:  count_nxt_s = count_r;
    endcase
    overflow_nxt_s  = (write & ~wr_acc_s) | (overflow_r  & ~clear_err);
    underflow_nxt_s = (read  & ~rd_acc_s) | (underflow_r & ~clear_err);
  end

  // Pointer, count and error state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= PTR_ZERO;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Output mapping; flags are pure decodes of registered state.
  always_comb begin
    wr_en        = wr_acc_s;
    rd_en        = rd_acc_s;
    wr_addr      = wr_ptr_r[ADDR_WIDTH-1:0];
    rd_addr      = rd_ptr_r[ADDR_WIDTH-1:0];
    empty        = empty_s;
    full         = full_s;
    almost_empty = (count_r <= AE_LEVEL);
    almost_full  = (count_r >= AF_LEVEL);
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FIFO top: storage array plus registered read port around fifo_ptr_ctrl.
// Read data appears one cycle after an accepted read, flagged by rd_valid.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = default_af_thresh(ADDR_WIDTH),
  parameter int AE_THRESH  = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .clear_err    (clear_err),
    .wr_en        (wr_en_s),
    .rd_en        (rd_en_s),
    .wr_addr      (wr_addr_s),
    .rd_addr      (rd_addr_s),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

  // Registered read port; non-blocking read gives the old word when full read+write share a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en_s;
      if (rd_en_s) begin
        rd_data_r <= mem_r[rd_addr_s];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Output mapping.
  always_comb begin
    rd_data  = rd_data_r;
    rd_valid = rd_valid_r;
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer (DEPTH=4): reference queue model plus a
// scoreboard of expected read words popped when rd_valid is seen.
module tb_fifo_buffer;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF_T  = 3;
  localparam int AE_T  = 1;

  logic          clk;
  logic          reset;
  logic          write;
  logic [DW-1:0] wr_data;
  logic          read;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          clear_err;

  int checks;
  int failures;

  logic [DW-1:0] m_q [$];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] m_last;
  logic          m_ovf;
  logic          m_unf;
  logic          m_valid;

  fifo_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF_T),
    .AE_THRESH  (AE_T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .wr_data      (wr_data),
    .read         (read),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clear_err    (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_state();
    int n;
    n = m_q.size();
    check("count",        32'(count),        32'(n));
    check("empty",        32'(empty),        32'(n == 0));
    check("full",         32'(full),         32'(n == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE_T));
    check("almost_full",  32'(almost_full),  32'(n >= AF_T));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    check("rd_valid",     32'(rd_valid),     32'(m_valid));
    check("rd_data_hold", 32'(rd_data),      32'(m_last));
    if (rd_valid === 1'b1) begin
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        check("sb_data", 32'(rd_data), 32'(sb_q.pop_front()));
      end
    end
  endtask

  // One clock of stimulus; the model advances from the same start-of-cycle state.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic ce);
    logic wacc;
    logic racc;
    logic [DW-1:0] popped;
    wacc = w && ((m_q.size() != DEPTH) || r);
    racc = r && (m_q.size() != 0);
    write = w; wr_data = d; read = r; clear_err = ce;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; clear_err = 1'b0;
    if (racc) begin
      popped = m_q.pop_front();
      sb_q.push_back(popped);
      m_last = popped;
    end
    if (wacc) m_q.push_back(d);
    m_ovf   = (w && !wacc) ? 1'b1 : (ce ? 1'b0 : m_ovf);
    m_unf   = (r && !racc) ? 1'b1 : (ce ? 1'b0 : m_unf);
    m_valid = racc;
    compare_state();
  endtask

  task automatic do_reset(input logic w);
    reset = 1'b1; write = w; wr_data = 8'hEE; read = 1'b0; clear_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; write = 1'b0;
    m_q.delete();
    sb_q.delete();
    m_last = 8'h00; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
    compare_state();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; write = 1'b0; wr_data = 8'h00; read = 1'b0; clear_err = 1'b0;

    do_reset(1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);

    // Drain, one rejected read, then clear errors.
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Steady-state read+write at count=2 across pointer wrap.
    step(1'b1, 8'h50, 1'b0, 1'b0);
    step(1'b1, 8'h51, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Read+write while full, then drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hC9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Read+write while empty, then normal read.
    step(1'b1, 8'hD1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // New error in the same cycle as clear_err keeps the flag set.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-stream with a write pending.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
